demux_stream_router_1x8: RTL and testbench

// - Registered, flow-controlled 1-to-8 stream router: steers each accepted input word to one of 8 output channels by a 3-bit select.
// - Sits where the combinational 1x8 demux leaves off: adds valid/ready handshakes, one-entry per-channel output buffering, channel masking and drop accounting.
// - Feeds eight independent downstream consumers; one stalled channel never blocks traffic to the others once its word is parked.

---
 rtl/demux_router_pkg.sv | 15 +
 rtl/demux_out_slot.sv | 33 +++
 rtl/demux_stream_router_1x8.sv | 67 ++++++
 tb/tb_demux_stream_router_1x8.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_router_pkg.sv
// Shared constants and types for the 1x8 stream router.
// The channel select type and the one-hot decode live here so the top and the bench agree on them.
package demux_router_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0] ch_sel_t;

  function automatic logic [NUM_CH-1:0] sel_onehot(input ch_sel_t sel);
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register slice for a single router channel.
// A load always wins over a drain, which gives full throughput when both happen together.
module demux_out_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      // NOTE: the data register is reset too, so m_data reads as zero after reset
      // instead of as X; it is a single word per channel, not a RAM array.
      data  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its inputs from before the edge, independent of statement order.
      if (load) begin
        valid <= 1'b1;
        data  <= load_data;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/demux_stream_router_1x8.sv
// Registered, flow-controlled 1-to-8 stream router with channel masking and drop accounting.
// Each channel owns a one-entry slot, so one stalled consumer never blocks the others.
module demux_stream_router_1x8
  import demux_router_pkg::*;
#(
  parameter int DW     = 8,
  parameter int DROP_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DW-1:0]        s_data,
  input  ch_sel_t              s_sel,
  input  logic [NUM_CH-1:0]    ch_en,
  output logic [NUM_CH-1:0]    m_valid,
  input  logic [NUM_CH-1:0]    m_ready,
  output logic [NUM_CH*DW-1:0] m_data,
  output logic [DROP_W-1:0]    drop_cnt
);

  logic [NUM_CH-1:0] load;
  logic              sel_en;
  logic              accept;
  logic              drop;

  // s_ready depends only on the selected slot and its consumer, never on s_valid.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves one unassigned and no latch is inferred.
    sel_en  = ch_en[s_sel];
    s_ready = 1'b1;
    load    = '0;
    if (sel_en) begin
      s_ready = ~m_valid[s_sel] | m_ready[s_sel];
    end
    accept = s_valid & s_ready;
    drop   = accept & ~sel_en;
    if (accept && sel_en) begin
      load = sel_onehot(s_sel);
    end
  end

  // Saturating count of words accepted for disabled channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != {DROP_W{1'b1}})) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_out_slot #(
      .DW(DW)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .load_data(s_data),
      .ready    (m_ready[k]),
      .valid    (m_valid[k]),
      .data     (m_data[k*DW +: DW])
    );
  end

endmodule

// File: tb/tb_demux_stream_router_1x8.sv
// Scoreboard bench for demux_stream_router_1x8: the driver queues expected words per channel,
// a monitor pops and compares whenever a channel handshake occurs.
module tb_demux_stream_router_1x8;
  import demux_router_pkg::*;

  localparam int DW     = 8;
  localparam int DROP_W = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 s_valid;
  logic                 s_ready;
  logic [DW-1:0]        s_data;
  ch_sel_t              s_sel;
  logic [NUM_CH-1:0]    ch_en;
  logic [NUM_CH-1:0]    m_valid;
  logic [NUM_CH-1:0]    m_ready;
  logic [NUM_CH*DW-1:0] m_data;
  logic [DROP_W-1:0]    drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_drop = 0;
  logic [DW-1:0] exp_q [NUM_CH][$];

  demux_stream_router_1x8 #(.DW(DW), .DROP_W(DROP_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_sel   (s_sel),
    .ch_en   (ch_en),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen at the falling edge completes at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (m_valid[k] && m_ready[k]) begin
            if (exp_q[k].size() == 0) begin
              check($sformatf("unexpected_word_ch%0d", k), 32'(m_data[k*DW +: DW]), 32'hDEAD);
            end else begin
              check($sformatf("data_ch%0d", k), 32'(m_data[k*DW +: DW]), 32'(exp_q[k].pop_front()));
            end
          end
        end
      end
    end
  end

  // Hold the current word until accepted; returns the number of stalled cycles.
  task automatic wait_accept(output int waited);
    waited = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (s_ready) begin
        if (ch_en[s_sel]) exp_q[s_sel].push_back(s_data);
        else if (exp_drop < 255) exp_drop++;
        @(posedge clk);
        #1;
        return;
      end
      waited++;
    end
    check("accept_timeout", 32'(waited), 32'd0);
  endtask

  task automatic send(input ch_sel_t sel, input logic [DW-1:0] data, output int waited);
    s_valid = 1'b1;
    s_sel   = sel;
    s_data  = data;
    wait_accept(waited);
  endtask

  task automatic idle();
    s_valid = 1'b0;
  endtask

  // Assert reset mid-cycle and confirm it clears outputs before the next rising edge.
  task automatic mid_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_m_valid", 32'(m_valid), 32'h0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    check("rst_m_data", m_data[31:0] | m_data[63:32], 32'h0);
    for (int k = 0; k < NUM_CH; k++) exp_q[k].delete();
    exp_drop = 0;
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int w;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_sel   = '0;
    ch_en   = 8'hFF;
    m_ready = 8'hFF;
    #1;
    check("reset_m_valid", 32'(m_valid), 32'h0);
    check("reset_drop_cnt", 32'(drop_cnt), 32'h0);
    check("reset_s_ready", 32'(s_ready), 32'h1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single word to channel 3.
    send(3'd3, 8'hA5, w);
    idle();
    check("a5_wait", 32'(w), 32'd0);
    @(negedge clk);
    check("a5_m_valid", 32'(m_valid), 32'h08);
    check("a5_data", 32'(m_data[3*DW +: DW]), 32'hA5);
    @(negedge clk);
    check("a5_drained", 32'(m_valid), 32'h00);
    check("a5_data_held", 32'(m_data[3*DW +: DW]), 32'hA5);

    // Backpressure on channel 5.
    @(posedge clk); #1;
    m_ready[5] = 1'b0;
    send(3'd5, 8'h11, w);
    s_data = 8'h22;
    repeat (3) begin
      @(negedge clk);
      check("ch5_stall_s_ready", 32'(s_ready), 32'h0);
    end
    check("ch5_parked", 32'(m_data[5*DW +: DW]), 32'h11);
    @(posedge clk); #1;
    m_ready[5] = 1'b1;
    wait_accept(w);
    idle();
    check("ch5_release_wait", 32'(w), 32'd0);
    @(negedge clk);
    check("ch5_new_word", 32'(m_data[5*DW +: DW]), 32'h22);
    @(negedge clk);
    check("ch5_empty", 32'(m_valid[5]), 32'h0);

    // Channel 1 stalled does not block channel 2.
    @(posedge clk); #1;
    m_ready[1] = 1'b0;
    send(3'd1, 8'h77, w);
    for (int i = 0; i < 4; i++) begin
      send(3'd2, 8'(8'h30 + i), w);
      check("ch2_stream_wait", 32'(w), 32'd0);
    end
    idle();
    @(negedge clk);
    check("ch1_still_parked", 32'(m_valid[1]), 32'h1);
    check("ch1_data_unchanged", 32'(m_data[1*DW +: DW]), 32'h77);
    @(posedge clk); #1;
    m_ready[1] = 1'b1;

    // Back-to-back 1,2,3,4 on channel 0.
    for (int i = 1; i <= 4; i++) begin
      send(3'd0, 8'(i), w);
      check("ch0_stream_wait", 32'(w), 32'd0);
    end
    idle();

    // Disabling an occupied channel still delivers the parked word.
    @(posedge clk); #1;
    m_ready[6] = 1'b0;
    send(3'd6, 8'h66, w);
    idle();
    ch_en[6] = 1'b0;
    send(3'd6, 8'h99, w);
    idle();
    check("ch6_drop_wait", 32'(w), 32'd0);
    @(negedge clk);
    check("ch6_parked_kept", 32'(m_data[6*DW +: DW]), 32'h66);
    check("ch6_drop_cnt", 32'(drop_cnt), 32'd1);
    @(posedge clk); #1;
    m_ready[6] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ch6_drained", 32'(m_valid[6]), 32'h0);

    // 300 words to disabled channel 7: saturates the drop counter.
    ch_en[7] = 1'b0;
    for (int i = 0; i < 300; i++) begin
      send(3'd7, 8'(i), w);
      if (w != 0) check("ch7_drop_wait", 32'(w), 32'd0);
    end
    idle();
    @(negedge clk);
    check("ch7_m_valid", 32'(m_valid[7]), 32'h0);
    check("drop_cnt_model", 32'(drop_cnt), 32'(exp_drop));
    check("drop_cnt_sat", 32'(drop_cnt), 32'd255);

    // Nine drops and a parked word on channel 4, then mid-cycle reset.
    mid_reset();
    for (int i = 0; i < 9; i++) send(3'd7, 8'hE0, w);
    m_ready[4] = 1'b0;
    send(3'd4, 8'h44, w);
    idle();
    @(negedge clk);
    check("pre_rst_drop_cnt", 32'(drop_cnt), 32'd9);
    check("pre_rst_ch4", 32'(m_valid), 32'h10);
    mid_reset();
    m_ready = 8'hFF;
    ch_en   = 8'hFF;

    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < NUM_CH; k++) begin
      check($sformatf("queue_empty_ch%0d", k), 32'(exp_q[k].size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
